// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter sequencing: pick an owner, present the address, wait for the response
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    // Which pipeline port currently holds the memory bus
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [3:0] WEN_READ  = 4'b0000;
    localparam logic [3:0] WSTRB_ALL = 4'b1111;

    // Reads fetch the whole word; writes only touch the enabled byte lanes
    function automatic logic [3:0] strobesFor(input logic [3:0] wen);
        return (wen == WEN_READ) ? WSTRB_ALL : wen;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb2_sel.sv
// Two-way grant selector between the fetch port and the data port.
module arb2_sel
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic   instElig_i,
    input  logic   dataElig_i,
    input  owner_e lastOwner_i,
    output owner_e grant_o
);

    // Resolve the winner; with nobody eligible the caller ignores the result
    always_comb begin
        grant_o = OWN_INST;
        if (instElig_i && dataElig_i) begin
            if (DATA_PRIO) begin
                grant_o = OWN_DATA;
            end else begin
                grant_o = (lastOwner_i == OWN_INST) ? OWN_DATA : OWN_INST;
            end
        end else if (dataElig_i) begin
            grant_o = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// one outstanding transaction at a time, with flush-driven fetch discard.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ok,
    output logic              i_stall,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ok,
    output logic              d_stall,
    input  logic              flush,
    output logic              m_req,
    output logic              m_wr,
    output logic [3:0]        m_wstrb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    // The fetch port never writes
    localparam logic [3:0] FETCH_WEN = WEN_READ;

    arb_state_e        state_q;
    owner_e            owner_q;
    owner_e            lastOwner_q;
    logic              discard_q;
    logic              mReq_q;
    logic              mWr_q;
    logic [3:0]        mWstrb_q;
    logic [ADDR_W-1:0] mAddr_q;
    logic [DATA_W-1:0] mWdata_q;
    logic [DATA_W-1:0] iRdata_q;
    logic              iOk_q;
    logic [DATA_W-1:0] dRdata_q;
    logic              dOk_q;

    logic   instElig;
    logic   dataElig;
    owner_e grant;

    // A port retiring this cycle must not be granted again, and a flush kills fetch
    assign instElig = i_req & ~iOk_q & ~flush;
    assign dataElig = d_req & ~dOk_q;

    arb2_sel #(
        .DATA_PRIO(DATA_PRIO)
    ) u_sel (
        .instElig_i (instElig),
        .dataElig_i (dataElig),
        .lastOwner_i(lastOwner_q),
        .grant_o    (grant)
    );

    assign m_req   = mReq_q;
    assign m_wr    = mWr_q;
    assign m_wstrb = mWstrb_q;
    assign m_addr  = mAddr_q;
    assign m_wdata = mWdata_q;
    assign i_rdata = iRdata_q;
    assign i_ok    = iOk_q;
    assign d_rdata = dRdata_q;
    assign d_ok    = dOk_q;

    // Stalls are combinational so the hazard unit freezes stages in the same cycle
    assign i_stall = i_req & ~iOk_q;
    assign d_stall = d_req & ~dOk_q;

    // Arbitration FSM with latched request, discard tracking and registered responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_INST;
            lastOwner_q <= OWN_INST;
            discard_q   <= 1'b0;
            mReq_q      <= 1'b0;
            mWr_q       <= 1'b0;
            mWstrb_q    <= '0;
            mAddr_q     <= '0;
            mWdata_q    <= '0;
            iRdata_q    <= '0;
            iOk_q       <= 1'b0;
            dRdata_q    <= '0;
            dOk_q       <= 1'b0;
        end else begin
            iOk_q <= 1'b0;
            dOk_q <= 1'b0;
            if (flush && owner_q == OWN_INST && state_q != ARB_IDLE) begin
                discard_q <= 1'b1;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (instElig || dataElig) begin
                        owner_q     <= grant;
                        lastOwner_q <= grant;
                        mReq_q      <= 1'b1;
                        state_q     <= ARB_ADDR;
                        if (grant == OWN_DATA) begin
                            mAddr_q  <= d_addr;
                            mWdata_q <= d_wdata;
                            mWr_q    <= |d_wen;
                            mWstrb_q <= strobesFor(d_wen);
                        end else begin
                            mAddr_q  <= i_addr;
                            mWdata_q <= '0;
                            mWr_q    <= |FETCH_WEN;
                            mWstrb_q <= strobesFor(FETCH_WEN);
                        end
                    end
                end
                ARB_ADDR: begin
                    if (m_addr_ok) begin
                        mReq_q  <= 1'b0;
                        state_q <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (m_data_ok) begin
                        state_q <= ARB_IDLE;
                        if (owner_q == OWN_DATA) begin
                            dRdata_q <= m_rdata;
                            dOk_q    <= 1'b1;
                        end else if (discard_q || flush) begin
                            discard_q <= 1'b0;
                        end else begin
                            iRdata_q <= m_rdata;
                            iOk_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    mReq_q  <= 1'b0;
                end
            endcase
        end
    end

    // A response in the same cycle as address acceptance breaks the memory protocol
    addrDataSameCycle: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == ARB_ADDR && m_addr_ok && m_data_ok));

endmodule
